// File: rtl/w2421_pkg.sv
// Shared types and constants for the BCD -> Weighted-2421 stream encoder.
//   w2421_state_e : encoder FSM states
//   W2421_DIGIT_W : bits per digit
//   BCD_MAX       : largest legal BCD digit
//   W2421_CODES   : 2421 code for each legal BCD digit, indexed by digit value
package w2421_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } w2421_state_e;

  localparam int W2421_DIGIT_W = 4;
  localparam int BCD_MAX       = 9;

  // Entry [d] is the code for digit d; 5..9 use the upper "2" weight.
  localparam logic [BCD_MAX:0][W2421_DIGIT_W-1:0] W2421_CODES = {
    4'b1111,  // 9
    4'b1110,  // 8
    4'b1101,  // 7
    4'b1100,  // 6
    4'b1011,  // 5
    4'b0100,  // 4
    4'b0011,  // 3
    4'b0010,  // 2
    4'b0001,  // 1
    4'b0000   // 0
  };

endpackage

// File: rtl/bcd_digit_to_2421.sv
// Combinational single-digit BCD -> Weighted-2421 encoder.
//   bcd_i     : 4-bit BCD digit
//   code_o    : 4-bit 2421 code (0000 when the digit is illegal)
//   invalid_o : set when bcd_i > 9
module bcd_digit_to_2421
  import w2421_pkg::*;
(
  input  logic [W2421_DIGIT_W-1:0] bcd_i,
  output logic [W2421_DIGIT_W-1:0] code_o,
  output logic                     invalid_o
);

  always_comb begin
    code_o    = '0;
    invalid_o = 1'b1;
    if (bcd_i <= W2421_DIGIT_W'(BCD_MAX)) begin
      code_o    = W2421_CODES[bcd_i];
      invalid_o = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_to_2421_stream.sv
// Sequential BCD -> Weighted-2421 word encoder, one digit per clock,
// valid/ready handshake on both sides.
//   clk, rst          : clock, synchronous active-high reset
//   in_bcd/in_valid/in_ready       : input word handshake
//   out_2421/out_err_mask/out_err  : encoded word and per-digit error flags
//   out_valid/out_ready            : output word handshake
//   out_parity        : odd parity over out_2421 (only with W2421_PARITY_EN)
// Optional feature macro: W2421_PARITY_EN
module bcd_to_2421_stream
  import w2421_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [W2421_DIGIT_W*NDIGITS-1:0]  in_bcd,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [W2421_DIGIT_W*NDIGITS-1:0]  out_2421,
  output logic [NDIGITS-1:0]                out_err_mask,
  output logic                              out_err,
  output logic                              out_valid,
  input  logic                              out_ready
`ifdef W2421_PARITY_EN
  ,
  output logic                              out_parity
`endif
);

  localparam int WW = W2421_DIGIT_W * NDIGITS;
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

  w2421_state_e            state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WW-1:0]           bcd_q, bcd_d;
  logic [WW-1:0]           code_q, code_d;
  logic [NDIGITS-1:0]      mask_q, mask_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
`ifdef W2421_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  logic [W2421_DIGIT_W-1:0] digit_sel;
  logic [W2421_DIGIT_W-1:0] digit_code;
  logic                     digit_inv;

  // Digit mux driven by the counter; a compare loop keeps the select
  // width-clean for any NDIGITS.
  always_comb begin
    digit_sel = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (cnt_q == CW'(i)) digit_sel = bcd_q[i*W2421_DIGIT_W +: W2421_DIGIT_W];
    end
  end

  bcd_digit_to_2421 u_digit (
    .bcd_i     (digit_sel),
    .code_o    (digit_code),
    .invalid_o (digit_inv)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    code_d   = code_q;
    mask_d   = mask_q;
`ifdef W2421_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_d    = in_bcd;
          cnt_d    = '0;
          code_d   = '0;
          mask_d   = '0;
`ifdef W2421_PARITY_EN
          parity_d = 1'b0;
`endif
          state_d  = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < NDIGITS; i++) begin
          if (cnt_q == CW'(i)) begin
            code_d[i*W2421_DIGIT_W +: W2421_DIGIT_W] = digit_code;
            mask_d[i] = digit_inv;
          end
        end
        if (cnt_q == LAST) begin
          // Counter holds at the last digit rather than wrapping.
          state_d  = DONE;
`ifdef W2421_PARITY_EN
          parity_d = ~^code_d;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered copies of the next state.
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bcd_q    <= '0;
      code_q   <= '0;
      mask_q   <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
`ifdef W2421_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      code_q   <= code_d;
      mask_q   <= mask_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
`ifdef W2421_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign in_ready     = ready_q;
  assign out_valid    = valid_q;
  assign out_2421     = code_q;
  assign out_err_mask = mask_q;
  assign out_err      = |mask_q;
`ifdef W2421_PARITY_EN
  assign out_parity   = parity_q;
`endif

endmodule

// File: tb/tb_bcd_to_2421_stream.sv
module tb_bcd_to_2421_stream;

  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] in_bcd;
  logic        in_valid, in_ready;
  logic [15:0] out_2421;
  logic [3:0]  out_err_mask;
  logic        out_err, out_valid, out_ready;
`ifdef W2421_PARITY_EN
  logic        out_parity;
`endif

  logic [3:0]  s_in_bcd, s_out_2421;
  logic        s_in_valid, s_in_ready;
  logic [0:0]  s_out_err_mask;
  logic        s_out_err, s_out_valid, s_out_ready;
`ifdef W2421_PARITY_EN
  logic        s_out_parity;
`endif

  bcd_to_2421_stream #(.NDIGITS(ND)) dut (
    .clk(clk), .rst(rst),
    .in_bcd(in_bcd), .in_valid(in_valid), .in_ready(in_ready),
    .out_2421(out_2421), .out_err_mask(out_err_mask), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef W2421_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  bcd_to_2421_stream #(.NDIGITS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_bcd(s_in_bcd), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_2421(s_out_2421), .out_err_mask(s_out_err_mask), .out_err(s_out_err),
    .out_valid(s_out_valid), .out_ready(s_out_ready)
`ifdef W2421_PARITY_EN
    , .out_parity(s_out_parity)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rr_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] code;
    logic [3:0]  mask;
    int          acc;
  } exp_t;
  exp_t sbq[$];

  // Reference: 0-4 map to themselves, 5-9 gain the upper weight (+6), >9 is 0.
  function automatic logic [3:0] enc(input int d);
    if (d > 9) return 4'd0;
    if (d < 5) return 4'(d);
    return 4'(d + 6);
  endfunction

  function automatic exp_t model(input logic [15:0] w, input int acc);
    exp_t e;
    e.code = '0;
    e.mask = '0;
    e.acc  = acc;
    for (int i = 0; i < ND; i++) begin
      int d;
      d = int'(w[i*4 +: 4]);
      e.code[i*4 +: 4] = enc(d);
      e.mask[i] = (d > 9);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency on out_valid rise, data on each output handshake.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          if (sbq.size() == 0) chk("unexpected_valid", 1, 0);
          else chk("latency", 64'(cyc - sbq[0].acc), ND);
        end
        if (out_valid && out_ready && sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("out_2421", out_2421, e.code);
          chk("out_err_mask", out_err_mask, e.mask);
          chk("out_err", out_err, |e.mask);
`ifdef W2421_PARITY_EN
          chk("out_parity", out_parity, ~^e.code);
`endif
        end
        prev_v = out_valid;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
    if (rr_en) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] w, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    in_bcd   = w;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_bcd   = 16'($urandom);  // must be ignored after capture
    if (push) sbq.push_back(model(w, cyc));
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_2421"}, out_2421, 0);
    chk({tag, "_out_err_mask"}, out_err_mask, 0);
    chk({tag, "_out_err"}, out_err, 0);
`ifdef W2421_PARITY_EN
    chk({tag, "_out_parity"}, out_parity, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t h;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_bcd = '0; s_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_reset("reset");
    chk("reset_s_in_ready", s_in_ready, 1);
    chk("reset_s_out_valid", s_out_valid, 0);
    rst = 1'b0;

    // Directed words
    send(16'h1234, 1'b1);
    send(16'h5678, 1'b1);
    send(16'h9A05, 1'b1);
    drain();

    // Backpressure: hold out_ready low in DONE
    out_ready = 1'b0;
    send(16'h3141, 1'b1);
    h = model(16'h3141, 0);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("hold_reach_done", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_2421, h.code);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    send(16'h0099, 1'b1);
    drain();

    // Reset during the second CONV cycle discards the word
    send(16'h8765, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk_reset("midconv");
    rst = 1'b0;
    send(16'h4321, 1'b1);
    drain();

    // Random words with random backpressure
    rr_en = 1'b1;
    for (int k = 0; k < 40; k++) send(16'($urandom), 1'b1);
    drain();
    rr_en = 1'b0;
    out_ready = 1'b1;
    drain();

    // NDIGITS=1 full code sweep at minimum word period
    for (int c = 0; c < 16; c++) begin
      chk("s_in_ready", s_in_ready, 1);
      s_in_bcd   = 4'(c);
      s_in_valid = 1'b1;
      @(posedge clk);
      #2;
      s_in_valid = 1'b0;
      s_in_bcd   = 4'($urandom);
      @(posedge clk);
      #2;
      chk("s_out_valid", s_out_valid, 1);
      chk("s_out_2421", s_out_2421, enc(c));
      chk("s_out_err", s_out_err, (c > 9));
      chk("s_out_err_mask", s_out_err_mask, (c > 9));
`ifdef W2421_PARITY_EN
      chk("s_out_parity", s_out_parity, ~^enc(c));
`endif
      @(posedge clk);
      #2;
      chk("s_out_valid_fall", s_out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
